// File: rtl/convertidor_bcd_pkg.sv
// Shared constants for the binary-to-BCD converter and the display path.
package convertidor_bcd_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    FIN       = 2'd2
  } estado_t;

  localparam int NUM_DIGITOS   = 3;
  localparam int ANCHO_DIGITO  = 4;
  localparam int ANCHO_SCRATCH = NUM_DIGITOS * ANCHO_DIGITO;

endpackage

// File: rtl/convertidor_bcd_if.sv
// Start/done handshake and digit bus between a requester and convertidor_bcd.
interface convertidor_bcd_if
  import convertidor_bcd_pkg::*;
  #(parameter int ANCHO = 8);

  logic [ANCHO-1:0]        binario;
  logic                    inicio;
  logic                    ocupado;
  logic                    listo;
  logic [ANCHO_DIGITO-1:0] centena;
  logic [ANCHO_DIGITO-1:0] decena;
  logic [ANCHO_DIGITO-1:0] unidad;

  modport master (
    output binario, inicio,
    input  ocupado, listo, centena, decena, unidad
  );

  modport slave (
    input  binario, inicio,
    output ocupado, listo, centena, decena, unidad
  );

endinterface

// File: rtl/convertidor_bcd_ajuste.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module ajuste_bcd
  import convertidor_bcd_pkg::*;
(
  input  logic [ANCHO_DIGITO-1:0] entrada,
  output logic [ANCHO_DIGITO-1:0] salida
);

  always_comb begin
    salida = entrada;
    if (entrada >= 4'd5) salida = entrada + 4'd3;
  end

endmodule

// File: rtl/convertidor_bcd.sv
// Serial binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// state     | meaning
// REPOSO    | idle, waiting for inicio; digits hold last result
// CONVIERTE | adjusting and shifting one bit per edge
// FIN       | listo high for one cycle, then back to REPOSO
module convertidor_bcd
  import convertidor_bcd_pkg::*;
  #(parameter int ANCHO = 8)
(
  input  logic              clk,
  input  logic              rst_n,
  convertidor_bcd_if.slave  bus
);

  estado_t                  estado;
  logic [ANCHO-1:0]         desplaza;
  logic [ANCHO_SCRATCH-1:0] scratch;
  logic [ANCHO_SCRATCH-1:0] ajustado;
  logic [ANCHO_SCRATCH+ANCHO-1:0] conjunto;
  logic [3:0]               cnt;
  logic                     ultimo;

  for (genvar d = 0; d < NUM_DIGITOS; d++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .entrada (scratch [d*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .salida  (ajustado[d*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  // Adjusted scratch and shift register move together as one wide word.
  assign conjunto = {ajustado, desplaza} << 1;
  assign ultimo   = (cnt == 4'(ANCHO - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado      <= REPOSO;
      desplaza    <= '0;
      scratch     <= '0;
      cnt         <= '0;
      bus.ocupado <= 1'b0;
      bus.listo   <= 1'b0;
      bus.centena <= '0;
      bus.decena  <= '0;
      bus.unidad  <= '0;
    end else begin
      bus.listo <= 1'b0;
      case (estado)
        REPOSO: begin
          if (bus.inicio) begin
            desplaza    <= bus.binario;
            scratch     <= '0;
            cnt         <= '0;
            bus.ocupado <= 1'b1;
            estado      <= CONVIERTE;
          end
        end
        CONVIERTE: begin
          scratch  <= conjunto[ANCHO +: ANCHO_SCRATCH];
          desplaza <= conjunto[ANCHO-1:0];
          if (ultimo) begin
            estado      <= FIN;
            bus.listo   <= 1'b1;
            bus.centena <= conjunto[ANCHO + 2*ANCHO_DIGITO +: ANCHO_DIGITO];
            bus.decena  <= conjunto[ANCHO +   ANCHO_DIGITO +: ANCHO_DIGITO];
            bus.unidad  <= conjunto[ANCHO                  +: ANCHO_DIGITO];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FIN: begin
          bus.ocupado <= 1'b0;
          estado      <= REPOSO;
        end
        default: begin
          bus.ocupado <= 1'b0;
          estado      <= REPOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convertidor_bcd.sv
// Randomized self-checking bench for convertidor_bcd against a divide/modulo model.
module tb_convertidor_bcd;

  localparam int ANCHO = 8;

  logic clk;
  logic rst_n;

  int errores = 0;
  int total   = 0;
  int exp_c   = 0;
  int exp_d   = 0;
  int exp_u   = 0;

  convertidor_bcd_if #(.ANCHO(ANCHO)) bus ();

  convertidor_bcd #(.ANCHO(ANCHO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprueba(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void espera_valor(input int v);
    exp_c = v / 100;
    exp_d = (v / 10) % 10;
    exp_u = v % 10;
  endfunction

  task automatic muestra();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_todo(input string tag, input int l, input int o);
    comprueba({tag, ".listo"},   int'(bus.listo),   l);
    comprueba({tag, ".ocupado"}, int'(bus.ocupado), o);
    comprueba({tag, ".centena"}, int'(bus.centena), exp_c);
    comprueba({tag, ".decena"},  int'(bus.decena),  exp_d);
    comprueba({tag, ".unidad"},  int'(bus.unidad),  exp_u);
  endtask

  // One conversion from idle: listo exactly ANCHO edges after acceptance,
  // busy through FIN, digits only change on the listo edge.
  task automatic run_conv(input string tag, input int v);
    logic [ANCHO-1:0] dato;
    dato = v[ANCHO-1:0];
    @(negedge clk);
    bus.binario = dato;
    bus.inicio  = 1'b1;
    muestra();
    bus.inicio  = 1'b0;
    bus.binario = ANCHO'($urandom);
    chk_todo(tag, 0, 1);
    for (int k = 1; k <= ANCHO + 1; k++) begin
      muestra();
      if (k == ANCHO) espera_valor(int'(dato));
      chk_todo(tag, (k == ANCHO) ? 1 : 0, (k <= ANCHO) ? 1 : 0);
    end
  endtask

  initial begin
    int acept;
    rst_n       = 1'b0;
    bus.inicio  = 1'b0;
    bus.binario = '0;

    repeat (2) muestra();
    chk_todo("reset", 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      muestra();
      chk_todo("idle", 0, 0);
    end

    run_conv("v255", 255);
    for (int k = 0; k < 10; k++) begin
      muestra();
      chk_todo("hold255", 0, 0);
    end
    run_conv("v0", 0);
    run_conv("v9", 9);
    run_conv("v99", 99);
    run_conv("v100", 100);

    for (int v = 0; v < 256; v++) run_conv("barrido", v);

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 3)) begin
        muestra();
        chk_todo("hueco", 0, 0);
      end
      run_conv("aleatorio", int'($urandom_range(0, 255)));
    end

    // inicio held high: one acceptance every ANCHO+2 edges.
    @(negedge clk);
    bus.binario = 8'd37;
    bus.inicio  = 1'b1;
    acept       = 0;
    for (int k = 0; k < 50; k++) begin
      muestra();
      if (k % (ANCHO + 2) == 0) acept = int'(bus.binario);
      if (k % (ANCHO + 2) == ANCHO) espera_valor(acept);
      chk_todo("continuo", (k % (ANCHO + 2) == ANCHO) ? 1 : 0,
               (k % (ANCHO + 2) == ANCHO + 1) ? 0 : 1);
      if (k == 23) bus.binario = 8'd200;
    end
    bus.inicio = 1'b0;
    comprueba("continuo.final", exp_c * 100 + exp_d * 10 + exp_u, 200);

    // Extra inicio pulses during CONVIERTE and FIN are dropped.
    @(negedge clk);
    bus.binario = 8'd128;
    bus.inicio  = 1'b1;
    for (int k = 0; k < 22; k++) begin
      muestra();
      bus.inicio = (k == 2 || k == 7 || k == 8) ? 1'b1 : 1'b0;
      if (k == ANCHO) espera_valor(128);
      chk_todo("ignora", (k == ANCHO) ? 1 : 0, (k <= ANCHO) ? 1 : 0);
    end

    // Reset landing on the 4th shift edge aborts without listo.
    @(negedge clk);
    bus.binario = 8'd255;
    bus.inicio  = 1'b1;
    muestra();
    bus.inicio = 1'b0;
    chk_todo("aborto.e0", 0, 1);
    for (int k = 1; k <= 3; k++) begin
      muestra();
      chk_todo("aborto.desp", 0, 1);
    end
    rst_n = 1'b0;
    muestra();
    espera_valor(0);
    chk_todo("aborto.rst", 0, 0);
    muestra();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      muestra();
      chk_todo("aborto.post", 0, 0);
    end
    run_conv("v42", 42);
    comprueba("v42.final", exp_c * 100 + exp_d * 10 + exp_u, 42);

    $display("Result: errors=%0d of %0d checks", errores, total);
    $finish;
  end

endmodule
